dram_device_model: RTL and testbench

- Synthesizable, cycle-accurate model of the external DRAM device; the `DRAM_*` pins of the DRAM wrapper connect directly to it.
- Decodes the RAS_n/CAS_n/write_n/enable_n sequence, latches the row and then the column, and returns read data after a fixed CAS latency. Writes are committed after a fixed write latency.
- Serves as the downstream memory for system simulation and for FPGA bring-up of the AHB DRAM path.

---
 rtl/dram_device_model.sv | 172 +++++++++++++++++
 tb/tb_dram_device_model.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_device_model.sv
// Cycle-accurate DRAM device model: decodes RAS/CAS/write/enable strobes,
// latches row then column, returns read data after READ_LAT cycles and
// commits writes after WRITE_LAT cycles.
module dram_device_model #(
    parameter int DRAMADDRWIDTH = 11,
    parameter int ROWADDRWIDTH  = 11,
    parameter int COLADDRWIDTH  = 10,
    parameter int DATAWIDTH     = 32,
    parameter int READ_LAT      = 5,
    parameter int WRITE_LAT     = 5
) (
    input  logic                     HCLK,
    input  logic                     HRESETn,
    input  logic [DATAWIDTH-1:0]     DRAM_in,
    input  logic [DRAMADDRWIDTH-1:0] DRAM_addr,
    input  logic                     DRAM_enable_n,
    input  logic                     DRAM_write_n,
    input  logic                     DRAM_RAS_n,
    input  logic                     DRAM_CAS_n,
    output logic [DATAWIDTH-1:0]     DRAM_out,
    output logic                     row_open,
    output logic                     data_valid,
    output logic                     protocol_err
);

    localparam int AW     = ROWADDRWIDTH + COLADDRWIDTH;
    localparam int MAXLAT = (READ_LAT > WRITE_LAT) ? READ_LAT : WRITE_LAT;
    localparam int CNTW   = (MAXLAT > 1) ? $clog2(MAXLAT) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ROWACT = 3'd1,
        RDWAIT = 3'd2,
        RDOUT  = 3'd3,
        WRWAIT = 3'd4,
        WRDONE = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic                    ras_q, cas_q;
    logic [ROWADDRWIDTH-1:0] row_q, row_d;
    logic [COLADDRWIDTH-1:0] col_q, col_d;
    logic [CNTW-1:0]         cnt_q, cnt_d;
    logic [DATAWIDTH-1:0]    out_q, out_d;
    logic                    dv_q, dv_d;
    logic                    err_q, err_d;
    logic                    mem_we;

    logic [DATAWIDTH-1:0]    mem [0:(1<<AW)-1];
    logic [AW-1:0]           mem_idx;
    logic [DATAWIDTH-1:0]    rd_word;

    logic ras_fall, cas_fall;

    assign ras_fall = !DRAM_RAS_n && ras_q;
    assign cas_fall = !DRAM_CAS_n && cas_q;
    assign mem_idx  = {row_q, col_q};
    assign rd_word  = mem[mem_idx];

    assign DRAM_out     = out_q;
    assign data_valid   = dv_q;
    assign protocol_err = err_q;
    assign row_open     = (state_q != IDLE);

    // Next-state decode: enable drop, then precharge (RAS high), then CAS handling.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        dv_d    = dv_q;
        err_d   = err_q;
        mem_we  = 1'b0;

        if (DRAM_enable_n) begin
            // Deselect drops any in-flight write; only that case is a violation.
            state_d = IDLE;
            dv_d    = 1'b0;
            out_d   = '0;
            if (state_q == WRWAIT) err_d = 1'b1;
        end else if ((state_q != IDLE) && DRAM_RAS_n) begin
            // Precharge; aborting a pending access is a violation.
            state_d = IDLE;
            dv_d    = 1'b0;
            out_d   = '0;
            if ((state_q == RDWAIT) || (state_q == WRWAIT)) err_d = 1'b1;
        end else begin
            if ((state_q != IDLE) && ras_fall) err_d = 1'b1;
            unique case (state_q)
                IDLE: begin
                    if (ras_fall) begin
                        state_d = ROWACT;
                        row_d   = DRAM_addr[ROWADDRWIDTH-1:0];
                    end
                    if (cas_fall) err_d = 1'b1;
                end
                ROWACT: begin
                    if (cas_fall) begin
                        col_d = DRAM_addr[COLADDRWIDTH-1:0];
                        if (!DRAM_write_n) begin
                            state_d = WRWAIT;
                            cnt_d   = CNTW'(WRITE_LAT - 1);
                        end else begin
                            state_d = RDWAIT;
                            cnt_d   = CNTW'(READ_LAT - 1);
                        end
                    end
                end
                RDWAIT: begin
                    if (cnt_q == '0) begin
                        out_d   = rd_word;
                        dv_d    = 1'b1;
                        state_d = RDOUT;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                RDOUT: begin
                    if (DRAM_CAS_n) begin
                        dv_d    = 1'b0;
                        out_d   = '0;
                        state_d = ROWACT;
                    end
                end
                WRWAIT: begin
                    if (cnt_q == '0) begin
                        mem_we  = 1'b1;
                        state_d = WRDONE;
                    end else begin
                        cnt_d = cnt_q - CNTW'(1);
                    end
                end
                WRDONE: begin
                    if (DRAM_CAS_n) state_d = ROWACT;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State and strobe-history registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            ras_q   <= 1'b1;
            cas_q   <= 1'b1;
            row_q   <= '0;
            col_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ras_q   <= DRAM_RAS_n;
            cas_q   <= DRAM_CAS_n;
            row_q   <= row_d;
            col_q   <= col_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            dv_q    <= dv_d;
            err_q   <= err_d;
        end
    end

    // Storage array; deliberately not reset so contents survive HRESETn.
    always_ff @(posedge HCLK) begin
        if (mem_we) mem[mem_idx] <= DRAM_in;
    end

endmodule

// File: tb/tb_dram_device_model.sv
// Directed bench for dram_device_model: stimulus pushes expected read data
// and arrival cycle; a monitor pops on each data_valid rise.
module tb_dram_device_model;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] DRAM_in;
    logic [10:0] DRAM_addr;
    logic        DRAM_enable_n;
    logic        DRAM_write_n;
    logic        DRAM_RAS_n;
    logic        DRAM_CAS_n;
    logic [31:0] DRAM_out;
    logic        row_open;
    logic        data_valid;
    logic        protocol_err;

    dram_device_model dut (
        .HCLK          (HCLK),
        .HRESETn       (HRESETn),
        .DRAM_in       (DRAM_in),
        .DRAM_addr     (DRAM_addr),
        .DRAM_enable_n (DRAM_enable_n),
        .DRAM_write_n  (DRAM_write_n),
        .DRAM_RAS_n    (DRAM_RAS_n),
        .DRAM_CAS_n    (DRAM_CAS_n),
        .DRAM_out      (DRAM_out),
        .row_open      (row_open),
        .data_valid    (data_valid),
        .protocol_err  (protocol_err)
    );

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic dv_prev = 1'b0;

    initial begin
        HCLK = 1'b0;
        forever #5 HCLK = ~HCLK;
    end

    always @(posedge HCLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compare read data and arrival cycle on every data_valid rise.
    always @(posedge HCLK) begin
        #1;
        if (data_valid && !dv_prev) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got data %h with empty scoreboard", DRAM_out);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rd_data", DRAM_out, e.data);
                chk("rd_latency_cyc", 32'(cyc), 32'(e.cyc));
            end
        end else if (!data_valid) begin
            chk("out_zero_when_invalid", DRAM_out, 32'h0);
        end
        dv_prev = data_valid;
    end

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic pins_idle();
        DRAM_enable_n = 1'b0;
        DRAM_RAS_n    = 1'b1;
        DRAM_CAS_n    = 1'b1;
        DRAM_write_n  = 1'b1;
    endtask

    task automatic open_row(input logic [10:0] row);
        DRAM_addr  = row;
        DRAM_RAS_n = 1'b0;
        tick();
    endtask

    // CAS fall; read data is due READ_LAT=5 edges after the sampling edge.
    task automatic cas(input logic [10:0] col, input bit we, input logic [31:0] d, input bit push);
        exp_t e;
        DRAM_addr    = col;
        DRAM_write_n = !we;
        DRAM_in      = d;
        DRAM_CAS_n   = 1'b0;
        if (!we && push) begin
            e.data = d;
            e.cyc  = cyc + 1 + 5;
            sb.push_back(e);
        end
        tick();
    endtask

    task automatic close_row();
        DRAM_CAS_n = 1'b1;
        tick();
        DRAM_RAS_n   = 1'b1;
        DRAM_write_n = 1'b1;
        tick();
    endtask

    task automatic do_write(input logic [10:0] row, input logic [10:0] col, input logic [31:0] d);
        open_row(row);
        cas(col, 1'b1, d, 1'b0);
        repeat (5) tick();
        close_row();
    endtask

    task automatic do_read(input logic [10:0] row, input logic [10:0] col, input logic [31:0] d);
        open_row(row);
        cas(col, 1'b0, d, 1'b1);
        repeat (6) tick();
        close_row();
    endtask

    initial begin
        pins_idle();
        DRAM_in   = '0;
        DRAM_addr = '0;
        HRESETn   = 1'b0;
        #12;
        chk("rst_out", DRAM_out, 32'h0);
        chk("rst_dv", {31'b0, data_valid}, 32'h0);
        chk("rst_row_open", {31'b0, row_open}, 32'h0);
        chk("rst_err", {31'b0, protocol_err}, 32'h0);
        tick();
        HRESETn = 1'b1;
        tick();

        // Preload three locations, including the top row / column 0.
        open_row(11'h123);
        chk("row_open_after_ras", {31'b0, row_open}, 32'h1);
        cas(11'h045, 1'b1, 32'hDEADBEEF, 1'b0);
        repeat (5) tick();
        close_row();
        do_write(11'h001, 11'h3FF, 32'h00000001);
        do_write(11'h7FF, 11'h000, 32'hA5A55A5A);

        // Read back; column bit 10 set must be ignored.
        do_read(11'h123, 11'h445, 32'hDEADBEEF);
        chk("err_after_rw", {31'b0, protocol_err}, 32'h0);

        // Latency: four quiet cycles, data on the fifth.
        open_row(11'h001);
        cas(11'h3FF, 1'b0, 32'h00000001, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("lat_early_dv", {31'b0, data_valid}, 32'h0);
        end
        tick();
        chk("lat_out", DRAM_out, 32'h00000001);
        chk("lat_dv", {31'b0, data_valid}, 32'h1);
        tick();
        chk("rdout_hold", DRAM_out, 32'h00000001);
        DRAM_CAS_n = 1'b1;
        tick();
        chk("dv_drop", {31'b0, data_valid}, 32'h0);
        chk("row_kept", {31'b0, row_open}, 32'h1);
        DRAM_RAS_n = 1'b1;
        tick();
        chk("precharge_row", {31'b0, row_open}, 32'h0);

        // Enable drop in RDOUT.
        open_row(11'h7FF);
        cas(11'h000, 1'b0, 32'hA5A55A5A, 1'b1);
        repeat (5) tick();
        chk("en_pre_dv", {31'b0, data_valid}, 32'h1);
        DRAM_enable_n = 1'b1;
        tick();
        chk("en_out", DRAM_out, 32'h0);
        chk("en_dv", {31'b0, data_valid}, 32'h0);
        chk("en_row", {31'b0, row_open}, 32'h0);
        chk("en_err", {31'b0, protocol_err}, 32'h0);
        pins_idle();
        tick();

        // Async reset mid-read; the aborted read is not expected.
        open_row(11'h123);
        cas(11'h045, 1'b0, 32'hDEADBEEF, 1'b0);
        tick();
        #3;
        HRESETn = 1'b0;
        #1;
        chk("arst_out", DRAM_out, 32'h0);
        chk("arst_dv", {31'b0, data_valid}, 32'h0);
        chk("arst_row", {31'b0, row_open}, 32'h0);
        pins_idle();
        tick();
        HRESETn = 1'b1;
        tick();
        do_read(11'h123, 11'h045, 32'hDEADBEEF);

        // Aborted write: RAS released one cycle into WRWAIT.
        open_row(11'h001);
        cas(11'h3FF, 1'b1, 32'h0BADBAD0, 1'b0);
        tick();
        DRAM_RAS_n = 1'b1;
        tick();
        chk("abort_row", {31'b0, row_open}, 32'h0);
        chk("abort_err", {31'b0, protocol_err}, 32'h1);
        DRAM_CAS_n   = 1'b1;
        DRAM_write_n = 1'b1;
        repeat (6) tick();
        do_read(11'h001, 11'h3FF, 32'h00000001);
        chk("err_sticky", {31'b0, protocol_err}, 32'h1);

        // Clear the sticky flag, then CAS fall with no open row.
        HRESETn = 1'b0;
        #1;
        chk("rst2_err", {31'b0, protocol_err}, 32'h0);
        tick();
        HRESETn = 1'b1;
        tick();
        DRAM_addr  = 11'h010;
        DRAM_CAS_n = 1'b0;
        tick();
        chk("idle_cas_err", {31'b0, protocol_err}, 32'h1);
        chk("idle_cas_row", {31'b0, row_open}, 32'h0);
        repeat (7) tick();
        chk("idle_cas_dv", {31'b0, data_valid}, 32'h0);
        DRAM_CAS_n = 1'b1;
        repeat (3) tick();

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
